// File: rtl/down_counter_3_bit_if.sv
// Control/status bundle for the loadable down counter.
// master drives load/enable, slave returns count and flags.
interface down_counter_3_bit_if #(
  parameter int WIDTH = 3
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             reload_en;
  logic [WIDTH-1:0] count;
  logic             zero;
  logic             borrow;
  logic             done;
  logic             busy;

  modport master (
    output load,
    output load_val,
    output en,
    output reload_en,
    input  count,
    input  zero,
    input  borrow,
    input  done,
    input  busy
  );

  modport slave (
    input  load,
    input  load_val,
    input  en,
    input  reload_en,
    output count,
    output zero,
    output borrow,
    output done,
    output busy
  );
endinterface

// File: rtl/down_counter_3_bit.sv
// Loadable down counter with one-shot / auto-reload modes.
// Emits a one-cycle borrow on underflow; done holds in one-shot.
module down_counter_3_bit #(
  parameter int WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  down_counter_3_bit_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nx;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_nx;
  logic [WIDTH-1:0] reload_r;
  logic [WIDTH-1:0] reload_nx;
  logic             borrow_r;
  logic             borrow_nx;
  logic             done_r;
  logic             done_nx;
  logic             busy_r;
  logic             busy_nx;
  logic             at_zero;

  assign at_zero = (count_r == '0);

  // State and datapath registers; reset aborts any run at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      count_r  <= '0;
      reload_r <= '0;
      borrow_r <= 1'b0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nx;
      count_r  <= count_nx;
      reload_r <= reload_nx;
      borrow_r <= borrow_nx;
      done_r   <= done_nx;
      busy_r   <= busy_nx;
    end
  end

  // Next state: load beats everything, else decrement or underflow.
  always_comb begin
    state_nx  = state_r;
    count_nx  = count_r;
    reload_nx = reload_r;
    borrow_nx = 1'b0;
    done_nx   = done_r;
    busy_nx   = busy_r;
    if (bus.load) begin
      state_nx  = RUN;
      count_nx  = bus.load_val;
      reload_nx = bus.load_val;
      done_nx   = 1'b0;
      busy_nx   = 1'b1;
    end else begin
      unique case (state_r)
        IDLE: begin
          busy_nx = 1'b0;
        end
        RUN: begin
          busy_nx = 1'b1;
          if (bus.en) begin
            if (!at_zero) begin
              count_nx = count_r - WIDTH'(1);
            end else begin
              borrow_nx = 1'b1;
              if (bus.reload_en) begin
                count_nx = reload_r;
              end else begin
                state_nx = DONE;
                count_nx = '0;
                done_nx  = 1'b1;
                busy_nx  = 1'b0;
              end
            end
          end
        end
        DONE: begin
          count_nx = '0;
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
        end
        default: begin
          state_nx = IDLE;
          count_nx = '0;
          done_nx  = 1'b0;
          busy_nx  = 1'b0;
        end
      endcase
    end
  end

  assign bus.count  = count_r;
  assign bus.zero   = at_zero;
  assign bus.borrow = borrow_r;
  assign bus.done   = done_r;
  assign bus.busy   = busy_r;

endmodule

// File: tb/tb_down_counter_3_bit.sv
// Directed vector bench for down_counter_3_bit.
// Table rows give inputs and outputs expected after the edge.
module tb_down_counter_3_bit;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  down_counter_3_bit_if #(.WIDTH(3)) bus ();

  down_counter_3_bit #(.WIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       ld;
    logic [2:0] lv;
    logic       en;
    logic       re;
    logic [2:0] c;
    logic       z;
    logic       b;
    logic       d;
    logic       bu;
  } vec_t;

  vec_t tbl[$];

  task automatic add(
    input logic       ld,
    input logic [2:0] lv,
    input logic       en,
    input logic       re,
    input logic [2:0] c,
    input logic       z,
    input logic       b,
    input logic       d,
    input logic       bu
  );
    vec_t v;
    v.ld = ld; v.lv = lv; v.en = en; v.re = re;
    v.c = c; v.z = z; v.b = b; v.d = d; v.bu = bu;
    tbl.push_back(v);
  endtask

  task automatic chk(
    input string      name,
    input logic [6:0] exp
  );
    logic [6:0] act;
    act = {bus.count, bus.zero, bus.borrow,
           bus.done, bus.busy};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got c/z/b/d/bu=%b exp %b",
               name, act, exp);
    end
  endtask

  task automatic step(
    input logic       ld,
    input logic [2:0] lv,
    input logic       en,
    input logic       re
  );
    bus.load      = ld;
    bus.load_val  = lv;
    bus.en        = en;
    bus.reload_en = re;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.load      = 1'b0;
    bus.load_val  = 3'd0;
    bus.en        = 1'b0;
    bus.reload_en = 1'b0;

    #1;
    chk("reset", {3'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    #20;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ld lv en re | c z b d bu
    // IDLE ignores en
    add(0, 0, 1, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1, 0, 0, 0);
    // one-shot load 5
    add(1, 5, 1, 0, 5, 0, 0, 0, 1);
    add(0, 0, 1, 0, 4, 0, 0, 0, 1);
    add(0, 0, 1, 0, 3, 0, 0, 0, 1);
    add(0, 0, 1, 0, 2, 0, 0, 0, 1);
    add(0, 0, 1, 0, 1, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 1, 0, 0, 1);
    add(0, 0, 1, 0, 0, 1, 1, 1, 0);
    add(0, 0, 1, 0, 0, 1, 0, 1, 0);
    // load 4 from DONE
    add(1, 4, 1, 0, 4, 0, 0, 0, 1);
    // enable gaps, load 2
    add(1, 2, 0, 0, 2, 0, 0, 0, 1);
    add(0, 0, 1, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 1, 0, 0, 1);
    add(0, 0, 1, 0, 0, 1, 1, 1, 0);
    add(0, 0, 1, 0, 0, 1, 0, 1, 0);
    // auto-reload load 3
    add(1, 3, 1, 1, 3, 0, 0, 0, 1);
    add(0, 0, 1, 1, 2, 0, 0, 0, 1);
    add(0, 0, 1, 1, 1, 0, 0, 0, 1);
    add(0, 0, 1, 1, 0, 1, 0, 0, 1);
    add(0, 0, 1, 1, 3, 0, 1, 0, 1);
    add(0, 0, 1, 1, 2, 0, 0, 0, 1);
    add(0, 0, 1, 1, 1, 0, 0, 0, 1);
    add(0, 0, 1, 1, 0, 1, 0, 0, 1);
    add(0, 0, 1, 1, 3, 0, 1, 0, 1);
    add(0, 0, 1, 1, 2, 0, 0, 0, 1);
    add(0, 0, 1, 1, 1, 0, 0, 0, 1);
    add(0, 0, 1, 1, 0, 1, 0, 0, 1);
    // load collides with underflow
    add(1, 6, 1, 1, 6, 0, 0, 0, 1);
    // load 7 reload: 8-cycle period
    add(1, 7, 1, 1, 7, 0, 0, 0, 1);
    add(0, 0, 1, 1, 6, 0, 0, 0, 1);
    add(0, 0, 1, 1, 5, 0, 0, 0, 1);
    add(0, 0, 1, 1, 4, 0, 0, 0, 1);
    add(0, 0, 1, 1, 3, 0, 0, 0, 1);
    add(0, 0, 1, 1, 2, 0, 0, 0, 1);
    add(0, 0, 1, 1, 1, 0, 0, 0, 1);
    add(0, 0, 1, 1, 0, 1, 0, 0, 1);
    add(0, 0, 1, 1, 7, 0, 1, 0, 1);
    add(0, 0, 1, 1, 6, 0, 0, 0, 1);
    // load 0 reload: borrow each enabled cycle
    add(1, 0, 1, 1, 0, 1, 0, 0, 1);
    add(0, 0, 1, 1, 0, 1, 1, 0, 1);
    add(0, 0, 1, 1, 0, 1, 1, 0, 1);
    add(0, 0, 0, 1, 0, 1, 0, 0, 1);
    add(0, 0, 1, 1, 0, 1, 1, 0, 1);
    // reload_en low at underflow ends run
    add(0, 0, 1, 0, 0, 1, 1, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].ld, tbl[i].lv, tbl[i].en, tbl[i].re);
      chk($sformatf("row%0d", i),
          {tbl[i].c, tbl[i].z, tbl[i].b,
           tbl[i].d, tbl[i].bu});
    end

    // reset mid-run: load 5, two decrements
    step(1, 5, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("pre_rst", {3'd3, 1'b0, 1'b0, 1'b0, 1'b1});
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", {3'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    #1;
    rst = 1'b0;
    step(0, 0, 1, 0);
    chk("rst_idle1", {3'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    step(0, 0, 1, 1);
    chk("rst_idle2", {3'd0, 1'b1, 1'b0, 1'b0, 1'b0});

    // reset held across an edge during reload run
    step(1, 2, 1, 1);
    chk("reload2", {3'd2, 1'b0, 1'b0, 1'b0, 1'b1});
    rst = 1'b1;
    step(1, 6, 1, 1);
    chk("rst_hold", {3'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    rst = 1'b0;
    step(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
